// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider.
//   DEFAULT_WIDTH : default operand/result width (legal range 4..64)
//   state_t       : controller state encoding (IDLE, RUN, FIX, DONE)
//   is_busy_state : helper, 1 for the states in which a divide is in flight
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == RUN) || (s == FIX);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle of the sequential divider.
//   ctrl_DIV        start pulse (master -> divider)
//   ctrl_signed     1 = two's-complement divide, sampled with ctrl_DIV
//   data_operandA   dividend, sampled with ctrl_DIV
//   data_operandB   divisor, sampled with ctrl_DIV
//   data_result     quotient      (divider -> master)
//   data_remainder  remainder
//   data_exception  divide-by-zero or signed overflow
//   data_resultRDY  one-cycle result-valid strobe
//   busy            high while a divide is in flight
//   dbg_state       current controller state, for observation only
//
// Handshake: a request is accepted on any rising edge where ctrl_DIV=1 and
// busy=0; requests seen while busy=1 are dropped. The result is valid on the
// single cycle where data_resultRDY=1 and the result fields then hold until
// the next result strobe.
// -----------------------------------------------------------------------------
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  state_t           dbg_state;

  modport master (
    output ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY,
    input  busy, dbg_state
  );

  modport slave (
    input  ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY,
    output busy, dbg_state
  );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational non-restoring step on a WIDTH+1 bit partial remainder.
//   i_rem     : partial remainder, already shifted left with the next dividend
//               bit in its LSB
//   i_divisor : divisor magnitude
//   i_sub     : 1 = subtract divisor, 0 = add divisor
//   o_rem     : new partial remainder
//   o_q_bit   : quotient bit (1 when the new remainder is non-negative)
// The arithmetic is modulo 2^(WIDTH+1); the true result always lies in
// [-divisor, divisor) and therefore fits, even if the shifted input wrapped.
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_sub,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_dvsr_ext;

  assign w_dvsr_ext = {1'b0, i_divisor};
  assign o_rem      = i_sub ? (i_rem - w_dvsr_ext) : (i_rem + w_dvsr_ext);
  assign o_q_bit    = ~o_rem[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle non-restoring divider, one quotient bit per clock.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : seq_divider_if.slave (request, result, status, debug state)
//
// Sequence: IDLE/DONE --start--> RUN (WIDTH steps) --> FIX --> DONE.
// A zero divisor skips RUN/FIX and goes straight to DONE with the exception
// flag set, result 0 and the dividend as remainder.
//
// Configuration macro SEQ_DIVIDER_SIGNED_EN:
//   defined   : ctrl_signed selects two's-complement divide (quotient truncates
//               toward zero, remainder takes the dividend's sign, MIN/-1 flags
//               an exception with result MIN and remainder 0).
//   undefined : ctrl_signed is ignored and every divide is unsigned; FIX still
//               takes one cycle so latency does not depend on the build.
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  seq_divider_if.slave  bus
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(WIDTH - 1);

  // Controller and datapath state
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   r_rem;     // signed partial remainder
  logic [WIDTH-1:0] r_quo;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_dvsr;    // divisor magnitude
  logic             r_ovf;

  // Registered outputs
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  // Operand conditioning
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_ovf;

  // Step and fix-up datapath
  logic [WIDTH:0]   w_shifted;
  logic             w_sub;
  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
  assign w_b_neg = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
  // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
  assign w_a_mag = w_a_neg ? -bus.data_operandA : bus.data_operandA;
  assign w_b_mag = w_b_neg ? -bus.data_operandB : bus.data_operandB;
  assign w_ovf   = bus.ctrl_signed && (bus.data_operandA == MIN_VAL) &&
                   (bus.data_operandB == '1);
`else
  logic w_unused_signed;

  assign w_unused_signed = bus.ctrl_signed;
  assign w_a_mag         = bus.data_operandA;
  assign w_b_mag         = bus.data_operandB;
  assign w_ovf           = 1'b0;
`endif

  // Shift {rem,quo} left by one; the operation depends on the sign of the
  // remainder before the shift.
  assign w_shifted = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_sub     = ~r_rem[WIDTH];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (w_shifted),
    .i_divisor (r_dvsr),
    .i_sub     (w_sub),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Restore a negative final remainder; the corrected value is in [0, divisor)
  // so the low WIDTH bits are exact.
  assign w_rem_mag = r_rem[WIDTH-1:0] + (r_rem[WIDTH] ? r_dvsr : '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign w_fix_quo = r_neg_q ? -r_quo : r_quo;
  assign w_fix_rem = r_neg_r ? -w_rem_mag : w_rem_mag;
`else
  assign w_fix_quo = r_quo;
  assign w_fix_rem = w_rem_mag;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_ovf       <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_exc       <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.ctrl_DIV) begin
            r_count <= '0;
            if (bus.data_operandB == '0) begin
              r_state     <= DONE;
              r_rdy       <= 1'b1;
              r_busy      <= 1'b0;
              r_result    <= '0;
              r_remainder <= bus.data_operandA;
              r_exc       <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_dvsr  <= w_b_mag;
              r_ovf   <= w_ovf;
`ifdef SEQ_DIVIDER_SIGNED_EN
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
`endif
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        RUN: begin
          r_rem   <= w_rem_next;
          r_quo   <= {r_quo[WIDTH-2:0], w_q_bit};
          r_count <= r_count + WIDTH'(1);
          if (r_count == LAST_CNT) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_result    <= w_fix_quo;
          r_remainder <= w_fix_rem;
          r_exc       <= r_ovf;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= DONE;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_remainder = r_remainder;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider: a 32-bit instance for the main cases and an
// 8-bit instance for narrow-width cases. Expected values are hand-computed;
// signed cases select their expectation by SEQ_DIVIDER_SIGNED_EN so the bench
// matches either build.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock;
  logic reset_n;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  seq_divider_if #(.WIDTH(32)) if32 ();
  seq_divider_if #(.WIDTH(8))  if8  ();

  seq_divider #(.WIDTH(32)) u_dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if32)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: {exception, remainder, quotient} for the 32-bit instance
  // ---------------------------------------------------------------------------
  logic [64:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
    if32.ctrl_DIV      = 1'b1;
    if32.ctrl_signed   = s;
    if32.data_operandA = a;
    if32.data_operandB = b;
    @(negedge clock);
    if32.ctrl_DIV = 1'b0;
  endtask

  task automatic push32(input logic [31:0] q, input logic [31:0] r, input logic e);
    exp_q.push_back({e, r, q});
  endtask

  // edges_in = edges already elapsed, counting the start edge as 1
  task automatic wait_rdy32(input string tag, input int exp_lat, input int edges_in);
    int edges;
    logic [64:0] exp;
    edges = edges_in;
    while (!if32.data_resultRDY && edges < 100) begin
      @(negedge clock);
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    exp = '0;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, " quotient"},  64'(if32.data_result),    64'(exp[31:0]));
    check({tag, " remainder"}, 64'(if32.data_remainder), 64'(exp[63:32]));
    check({tag, " exception"}, 64'(if32.data_exception), 64'(exp[64]));
  endtask

  task automatic do_div32(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] q, input logic [31:0] r,
                          input logic e, input int lat);
    push32(q, r, e);
    start32(a, b, s);
    wait_rdy32(tag, lat, 1);
  endtask

  task automatic do_div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [7:0] q, input logic [7:0] r,
                         input logic e, input int lat);
    int edges;
    if8.ctrl_DIV      = 1'b1;
    if8.ctrl_signed   = s;
    if8.data_operandA = a;
    if8.data_operandB = b;
    @(negedge clock);
    if8.ctrl_DIV = 1'b0;
    edges = 1;
    while (!if8.data_resultRDY && edges < 40) begin
      @(negedge clock);
      edges++;
    end
    check({tag, " latency"},   64'(edges),               64'(lat));
    check({tag, " quotient"},  64'(if8.data_result),     64'(q));
    check({tag, " remainder"}, 64'(if8.data_remainder),  64'(r));
    check({tag, " exception"}, 64'(if8.data_exception),  64'(e));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n_rdy;
    int edges;

    reset_n            = 1'b0;
    if32.ctrl_DIV      = 1'b0;
    if32.ctrl_signed   = 1'b0;
    if32.data_operandA = '0;
    if32.data_operandB = '0;
    if8.ctrl_DIV       = 1'b0;
    if8.ctrl_signed    = 1'b0;
    if8.data_operandA  = '0;
    if8.data_operandB  = '0;

    repeat (2) @(negedge clock);
    check("reset result",    64'(if32.data_result),    64'd0);
    check("reset remainder", 64'(if32.data_remainder), 64'd0);
    check("reset exception", 64'(if32.data_exception), 64'd0);
    check("reset rdy",       64'(if32.data_resultRDY), 64'd0);
    check("reset busy",      64'(if32.busy),           64'd0);
    check("reset state",     64'(if32.dbg_state),      64'(IDLE));
    check("reset rdy8",      64'(if8.data_resultRDY),  64'd0);

    // Release and start on the same falling edge: the first rising edge after
    // release must accept the request.
    reset_n = 1'b1;
    push32(32'd14, 32'd2, 1'b0);
    start32(32'd100, 32'd7, 1'b0);
    check("busy after start", 64'(if32.busy), 64'd1);
    wait_rdy32("u100/7", 34, 1);

    // Strobe is one cycle wide; results hold afterwards.
    @(negedge clock);
    check("rdy one cycle",  64'(if32.data_resultRDY), 64'd0);
    check("hold quotient",  64'(if32.data_result),    64'd14);
    check("hold remainder", 64'(if32.data_remainder), 64'd2);
    check("idle after done", 64'(if32.dbg_state),     64'(IDLE));

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div32("s-100/7",  32'hFFFF_FF9C, 32'd7,          1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    do_div32("s100/-7",  32'd100,       32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2, 32'd2,         1'b0, 34);
    do_div32("s-7/2",    32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    do_div32("sMIN/-1",  32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,         1'b1, 34);
    do_div32("s-5/0",    32'hFFFF_FFFB, 32'd0,          1'b1, 32'd0,         32'hFFFF_FFFB, 1'b1, 1);
`else
    do_div32("s-100/7",  32'hFFFF_FF9C, 32'd7,          1'b1, 32'd613566742, 32'd2,         1'b0, 34);
    do_div32("s100/-7",  32'd100,       32'hFFFF_FFF9,  1'b1, 32'd0,         32'd100,       1'b0, 34);
    do_div32("s-7/2",    32'hFFFF_FFF9, 32'd2,          1'b1, 32'd2147483644, 32'd1,        1'b0, 34);
    do_div32("sMIN/-1",  32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'd0,         32'h8000_0000, 1'b0, 34);
    do_div32("s-5/0",    32'hFFFF_FFFB, 32'd0,          1'b1, 32'd0,         32'hFFFF_FFFB, 1'b1, 1);
`endif
    do_div32("uMIN/-1",  32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'd0,         32'h8000_0000, 1'b0, 34);
    do_div32("u12345/0", 32'd12345,     32'd0,          1'b0, 32'd0,         32'd12345,     1'b1, 1);
    do_div32("u7/9",     32'd7,         32'd9,          1'b0, 32'd0,         32'd7,         1'b0, 34);
    do_div32("umax/1",   32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, 34);

    // Second request on cycle 5 of a run is dropped.
    push32(32'd333, 32'd1, 1'b0);
    start32(32'd1000, 32'd3, 1'b0);
    edges = 1;
    repeat (4) begin
      @(negedge clock);
      edges++;
    end
    if32.ctrl_DIV      = 1'b1;
    if32.data_operandA = 32'd7;
    if32.data_operandB = 32'd0;
    @(negedge clock);
    edges++;
    if32.ctrl_DIV = 1'b0;
    check("busy despite ctrl", 64'(if32.busy), 64'd1);
    wait_rdy32("ignored start", 34, edges);

    // Request during DONE starts the next divide immediately.
    do_div32("b2b first", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 34);
    do_div32("b2b second", 32'd77, 32'd10, 1'b0, 32'd7, 32'd7, 1'b0, 34);

    // Reset in the middle of a run, after a result with exception=1.
    do_div32("pre-reset 5/0", 32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1'b1, 1);
    start32(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrun reset result",    64'(if32.data_result),    64'd0);
    check("midrun reset remainder", 64'(if32.data_remainder), 64'd0);
    check("midrun reset exception", 64'(if32.data_exception), 64'd0);
    check("midrun reset busy",      64'(if32.busy),           64'd0);
    check("midrun reset rdy",       64'(if32.data_resultRDY), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    n_rdy = 0;
    repeat (40) begin
      @(negedge clock);
      if (if32.data_resultRDY) n_rdy++;
    end
    check("no rdy after reset", 64'(n_rdy), 64'd0);
    do_div32("after reset", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);

    // Narrow instance
    do_div8("w8 255/16", 8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0, 10);
    do_div8("w8 200/0",  8'd200, 8'd0,  1'b0, 8'd0,  8'd200, 1'b1, 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div8("w8 sMIN/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b1, 10);
    do_div8("w8 s-9/4",   8'hF7, 8'd4,  1'b1, 8'hFE, 8'hFF, 1'b0, 10);
`else
    do_div8("w8 sMIN/-1", 8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 10);
    do_div8("w8 s-9/4",   8'hF7, 8'd4,  1'b1, 8'd61, 8'd3,  1'b0, 10);
`endif

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
